// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: response codes and address-to-slot index helper for the AXI4-Lite register file
package axi_lite_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   function automatic int reg_index(input logic [63:0] addr, input int data_w);
      return 32'(addr >> $clog2(data_w / 8));
   endfunction
endpackage

// File: rtl/axi_lite_regfile_store.sv
// axi_lite_regfile_store: register storage with byte-strobe merge, read-only status mux and write pulses
module axi_lite_regfile_store
   import axi_lite_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W = 6,
   parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         wr_en_i,
   input  logic [ADDR_W-1:0]            wr_addr_i,
   input  logic [DATA_W-1:0]            wr_data_i,
   input  logic [DATA_W/8-1:0]          wr_strb_i,
   input  logic [ADDR_W-1:0]            rd_addr_i,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_status_i,
   output logic                         wr_err_o,
   output logic [DATA_W-1:0]            rd_data_o,
   output logic                         rd_err_o,
   output logic [NUM_REGS*DATA_W-1:0]   reg_o,
   output logic [NUM_REGS-1:0]          wr_pulse_o
);
   localparam int NB = DATA_W / 8;
   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [NUM_REGS-1:0] pulse_q, pulse_d, wr_sel;
   int wr_idx, rd_idx;
   assign wr_idx = reg_index(64'(wr_addr_i), DATA_W);
   assign rd_idx = reg_index(64'(rd_addr_i), DATA_W);
   always_comb begin
      regs_d = regs_q;
      pulse_d = '0;
      wr_sel = '0;
      rd_data_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         wr_sel[i] = (wr_idx == i) && !RO_MASK[i];
         pulse_d[i] = wr_en_i && wr_sel[i];
         for (int b = 0; b < NB; b++)
            if (pulse_d[i] && wr_strb_i[b]) regs_d[i][8*b +: 8] = wr_data_i[8*b +: 8];
         if (rd_idx == i) rd_data_o = RO_MASK[i] ? hw_status_i[i*DATA_W +: DATA_W] : regs_q[i];
      end
   end
   // out-of-range and read-only targets both leave wr_sel empty
   assign wr_err_o = ~|wr_sel;
   assign rd_err_o = rd_idx >= NUM_REGS;
   assign reg_o = regs_q;
   assign wr_pulse_o = pulse_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         regs_q <= '0;
         pulse_q <= '0;
      end else begin
         regs_q <= regs_d;
         pulse_q <= pulse_d;
      end
   end
endmodule

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: AXI4-Lite slave front end with independent AW/W holding registers and read channel
module axi_lite_regfile
   import axi_lite_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W = 6,
   parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
   input  logic                         ACLK,
   input  logic                         ARESETn,
   input  logic [ADDR_W-1:0]            S_AWADDR,
   input  logic                         S_AWVALID,
   output logic                         S_AWREADY,
   input  logic [DATA_W-1:0]            S_WDATA,
   input  logic [DATA_W/8-1:0]          S_WSTRB,
   input  logic                         S_WVALID,
   output logic                         S_WREADY,
   output logic [1:0]                   S_BRESP,
   output logic                         S_BVALID,
   input  logic                         S_BREADY,
   input  logic [ADDR_W-1:0]            S_ARADDR,
   input  logic                         S_ARVALID,
   output logic                         S_ARREADY,
   output logic [DATA_W-1:0]            S_RDATA,
   output logic [1:0]                   S_RRESP,
   output logic                         S_RVALID,
   input  logic                         S_RREADY,
   output logic [NUM_REGS*DATA_W-1:0]   reg_out,
   output logic [NUM_REGS-1:0]          wr_pulse,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_status
);
   logic aw_held_q, w_held_q, bvalid_q, rvalid_q;
   logic [ADDR_W-1:0] aw_addr_q;
   logic [DATA_W-1:0] w_data_q, rdata_q, rd_data;
   logic [DATA_W/8-1:0] w_strb_q;
   logic [1:0] bresp_q, rresp_q;
   logic aw_fire, w_fire, ar_fire, commit, wr_err, rd_err;
   assign S_AWREADY = !aw_held_q && !bvalid_q;
   assign S_WREADY = !w_held_q && !bvalid_q;
   assign S_ARREADY = !rvalid_q;
   assign S_BVALID = bvalid_q;
   assign S_BRESP = bresp_q;
   assign S_RVALID = rvalid_q;
   assign S_RDATA = rdata_q;
   assign S_RRESP = rresp_q;
   assign aw_fire = S_AWVALID && S_AWREADY;
   assign w_fire = S_WVALID && S_WREADY;
   assign ar_fire = S_ARVALID && S_ARREADY;
   // commit on the edge where the later of the two halves arrives
   assign commit = (aw_held_q || aw_fire) && (w_held_q || w_fire);
   axi_lite_regfile_store #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .RO_MASK(RO_MASK)
   ) u_store (
      .clk_i(ACLK),
      .rst_ni(ARESETn),
      .wr_en_i(commit),
      .wr_addr_i(aw_held_q ? aw_addr_q : S_AWADDR),
      .wr_data_i(w_held_q ? w_data_q : S_WDATA),
      .wr_strb_i(w_held_q ? w_strb_q : S_WSTRB),
      .rd_addr_i(S_ARADDR),
      .hw_status_i(hw_status),
      .wr_err_o(wr_err),
      .rd_data_o(rd_data),
      .rd_err_o(rd_err),
      .reg_o(reg_out),
      .wr_pulse_o(wr_pulse)
   );
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         aw_held_q <= 1'b0;
         w_held_q <= 1'b0;
         aw_addr_q <= '0;
         w_data_q <= '0;
         w_strb_q <= '0;
         bvalid_q <= 1'b0;
         bresp_q <= RESP_OKAY;
         rvalid_q <= 1'b0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else begin
         if (commit) begin
            aw_held_q <= 1'b0;
            w_held_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
         end else begin
            if (aw_fire) begin
               aw_held_q <= 1'b1;
               aw_addr_q <= S_AWADDR;
            end
            if (w_fire) begin
               w_held_q <= 1'b1;
               w_data_q <= S_WDATA;
               w_strb_q <= S_WSTRB;
            end
            if (S_BREADY) bvalid_q <= 1'b0;
         end
         if (ar_fire) begin
            rvalid_q <= 1'b1;
            rdata_q <= rd_err ? '0 : rd_data;
            rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
         end else if (S_RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb_axi_lite_regfile: directed checks of handshakes, strobes, RO/out-of-range errors, backpressure and reset
module tb_axi_lite_regfile;
   localparam int DW = 32;
   localparam int NR = 8;
   localparam int AW = 6;
   logic clk = 1'b0;
   logic rst_n;
   logic [AW-1:0] awaddr, araddr;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [DW/8-1:0] wstrb;
   logic [1:0] bresp, rresp;
   logic [NR*DW-1:0] reg_out, hw_status;
   logic [NR-1:0] wr_pulse;
   int n_tests = 0;
   int n_fail = 0;
   logic [31:0] rd_d;
   logic [1:0] rd_r;
   always #5 clk = ~clk;
   axi_lite_regfile #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .RO_MASK(8'h01)) dut (
      .ACLK(clk), .ARESETn(rst_n),
      .S_AWADDR(awaddr), .S_AWVALID(awvalid), .S_AWREADY(awready),
      .S_WDATA(wdata), .S_WSTRB(wstrb), .S_WVALID(wvalid), .S_WREADY(wready),
      .S_BRESP(bresp), .S_BVALID(bvalid), .S_BREADY(bready),
      .S_ARADDR(araddr), .S_ARVALID(arvalid), .S_ARREADY(arready),
      .S_RDATA(rdata), .S_RRESP(rresp), .S_RVALID(rvalid), .S_RREADY(rready),
      .reg_out(reg_out), .wr_pulse(wr_pulse), .hw_status(hw_status)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] slot(input int i);
      return reg_out[i*DW +: DW];
   endfunction
   task automatic wr_issue(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      for (int n = 0; n < 20 && !bvalid; n++) @(negedge clk);
      chk("bvalid_wait", 64'(bvalid), 64'(1));
   endtask
   task automatic b_ack();
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("bvalid_clr", 64'(bvalid), 64'(0));
   endtask
   task automatic rd(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r);
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      for (int n = 0; n < 20 && !rvalid; n++) @(negedge clk);
      chk("rvalid_wait", 64'(rvalid), 64'(1));
      d = rdata; r = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask
   initial begin
      rst_n = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      hw_status = {NR{32'h5A5A5A5A}};
      hw_status[31:0] = 32'hCAFE0000;
      #12;
      chk("rst_awready", 64'(awready), 64'(1));
      chk("rst_arready", 64'(arready), 64'(1));
      chk("rst_bvalid", 64'(bvalid), 64'(0));
      chk("rst_rdata", 64'(rdata), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      // basic write then read of slot 1
      wr_issue(6'h04, 32'hDEADBEEF, 4'hF);
      chk("w1_bresp", 64'(bresp), 64'(0));
      chk("w1_pulse", 64'(wr_pulse), 64'(8'h02));
      chk("w1_reg", 64'(slot(1)), 64'(32'hDEADBEEF));
      b_ack();
      chk("w1_pulse_off", 64'(wr_pulse), 64'(0));
      rd(6'h04, rd_d, rd_r);
      chk("r1_data", 64'(rd_d), 64'(32'hDEADBEEF));
      chk("r1_resp", 64'(rd_r), 64'(0));
      // W three cycles ahead of AW
      @(negedge clk);
      wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      chk("wf_wready", 64'(wready), 64'(0));
      chk("wf_awready", 64'(awready), 64'(1));
      repeat (2) @(negedge clk);
      chk("wf_nocommit", 64'(slot(2)), 64'(0));
      chk("wf_nobvalid", 64'(bvalid), 64'(0));
      awaddr = 6'h08; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      chk("wf_bvalid", 64'(bvalid), 64'(1));
      chk("wf_pulse", 64'(wr_pulse), 64'(8'h04));
      chk("wf_reg", 64'(slot(2)), 64'(32'h12345678));
      b_ack();
      // partial strobe merge
      wr_issue(6'h08, 32'hAABBCCDD, 4'b0101);
      chk("st_bresp", 64'(bresp), 64'(0));
      b_ack();
      rd(6'h08, rd_d, rd_r);
      chk("st_data", 64'(rd_d), 64'(32'h12BB56DD));
      // read-only slot and out-of-range accesses
      wr_issue(6'h00, 32'hFFFFFFFF, 4'hF);
      chk("ro_bresp", 64'(bresp), 64'(2));
      chk("ro_pulse", 64'(wr_pulse), 64'(0));
      chk("ro_reg", 64'(slot(0)), 64'(0));
      b_ack();
      rd(6'h00, rd_d, rd_r);
      chk("ro_rdata", 64'(rd_d), 64'(32'hCAFE0000));
      chk("ro_rresp", 64'(rd_r), 64'(0));
      rd(6'h3C, rd_d, rd_r);
      chk("oor_rdata", 64'(rd_d), 64'(0));
      chk("oor_rresp", 64'(rd_r), 64'(2));
      wr_issue(6'h20, 32'h13579BDF, 4'hF);
      chk("oor_bresp", 64'(bresp), 64'(2));
      chk("oor_pulse", 64'(wr_pulse), 64'(0));
      b_ack();
      // same slot read and written on one edge: read sees old value
      @(negedge clk);
      awaddr = 6'h04; awvalid = 1'b1; wdata = 32'h01020304; wstrb = 4'hF; wvalid = 1'b1;
      araddr = 6'h04; arvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("rw_rdata", 64'(rdata), 64'(32'hDEADBEEF));
      chk("rw_reg", 64'(slot(1)), 64'(32'h01020304));
      chk("rw_bvalid", 64'(bvalid), 64'(1));
      bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      // backpressure on B and R with a second write waiting
      @(negedge clk);
      awaddr = 6'h0C; awvalid = 1'b1; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
      araddr = 6'h04; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      awaddr = 6'h10; wdata = 32'h99999999;
      repeat (5) begin
         @(negedge clk);
         chk("bp_bvalid", 64'(bvalid), 64'(1));
         chk("bp_bresp", 64'(bresp), 64'(0));
         chk("bp_awready", 64'(awready), 64'(0));
         chk("bp_wready", 64'(wready), 64'(0));
         chk("bp_arready", 64'(arready), 64'(0));
         chk("bp_rvalid", 64'(rvalid), 64'(1));
         chk("bp_rdata", 64'(rdata), 64'(32'h01020304));
      end
      awvalid = 1'b0; wvalid = 1'b0;
      chk("bp_slot3", 64'(slot(3)), 64'(32'h11111111));
      chk("bp_slot4", 64'(slot(4)), 64'(0));
      bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      chk("bp_bclr", 64'(bvalid), 64'(0));
      chk("bp_rclr", 64'(rvalid), 64'(0));
      // asynchronous reset while a response is pending
      wr_issue(6'h14, 32'h77777777, 4'hF);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_bvalid", 64'(bvalid), 64'(0));
      chk("ar_bresp", 64'(bresp), 64'(0));
      chk("ar_awready", 64'(awready), 64'(1));
      chk("ar_wready", 64'(wready), 64'(1));
      chk("ar_arready", 64'(arready), 64'(1));
      chk("ar_regout", 64'(reg_out != '0), 64'(0));
      chk("ar_pulse", 64'(wr_pulse), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      rd(6'h04, rd_d, rd_r);
      chk("ar_rd_data", 64'(rd_d), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
